// File: rtl/or3_vector_sequencer.sv
// ---------------------------------------------------------------------------
// or3_vector_sequencer
//
// Exhaustive stimulus generator and checker wrapped around a 3-input OR cell.
// On start it walks {a,b,c} through 000..111 (a is the MSB). Each vector is
// held for HOLD_CYCLES clocks, y is sampled on the last edge of the hold, and
// mismatches against a|b|c are counted. A one-cycle done pulse and a pass
// flag report the result.
//
// Ports
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset
//   start      run request, accepted only while idle
//   y          OR cell output under test
//   a, b, c    OR cell inputs (a = vector MSB, c = LSB)
//   vec_idx    index of the vector being driven
//   busy       high from start acceptance until the final sample
//   done       one-cycle completion pulse
//   pass       1 when the last run had no mismatches; held until next start
//   err_count  mismatching samples in the current or last run (0..8)
//
// State | Meaning
// IDLE  | waiting for start; last result held on pass/err_count
// DRIVE | driving vec_idx onto a/b/c, counting hold cycles, sampling y
// DONE  | single cycle with done high, then back to IDLE
// ---------------------------------------------------------------------------
module or3_vector_sequencer #(
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [2:0] vec_idx,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] hold_cnt;
    logic       mismatch;
    logic [3:0] err_next;
    logic [2:0] vec_next;

    // Case equality so an X on y is scored as a mismatch in simulation.
    assign mismatch = !(y === (a | b | c));
    assign err_next = err_count + {3'b000, mismatch};
    assign vec_next = vec_idx + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a         <= 1'b0;
            b         <= 1'b0;
            c         <= 1'b0;
            vec_idx   <= 3'd0;
            hold_cnt  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= DRIVE;
                        vec_idx     <= 3'd0;
                        {a, b, c}   <= 3'b000;
                        hold_cnt    <= 4'd0;
                        busy        <= 1'b1;
                        err_count   <= 4'd0;
                        pass        <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (hold_cnt == HOLD_LAST) begin
                        err_count <= err_next;
                        hold_cnt  <= 4'd0;
                        if (vec_idx == 3'd7) begin
                            // pass uses err_next so the final sample is included.
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= (err_next == 4'd0);
                            vec_idx   <= 3'd0;
                            {a, b, c} <= 3'b000;
                        end else begin
                            vec_idx   <= vec_next;
                            {a, b, c} <= vec_next;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_or3_vector_sequencer.sv
module tb_or3_vector_sequencer;

    logic            clk;
    logic            rst_n;
    logic [1:0]      start_v;
    logic [1:0]      y_v;
    logic [1:0]      a_v, b_v, c_v;
    logic [1:0][2:0] vidx_v;
    logic [1:0]      busy_v, done_v, pass_v;
    logic [1:0][3:0] err_v;
    // Per-instance flip pattern: y for vector k is the true OR inverted when bit k is set.
    logic [1:0][7:0] mask_v;

    int checks = 0;
    int errors = 0;

    // Instance 0 holds each vector 2 cycles, instance 1 holds 1 cycle.
    or3_vector_sequencer #(.HOLD_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y(y_v[0]),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .vec_idx(vidx_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0])
    );

    or3_vector_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y(y_v[1]),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .vec_idx(vidx_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural OR cell with optional injected faults.
    always_comb begin
        y_v = '0;
        for (int d = 0; d < 2; d++) begin
            logic [2:0] idx;
            idx    = {a_v[d], b_v[d], c_v[d]};
            y_v[d] = (idx != 3'd0) ^ mask_v[d][idx];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_idle_zero(input int d, input string tag);
        chk({tag, "_abc"},  {29'd0, a_v[d], b_v[d], c_v[d]}, 32'd0);
        chk({tag, "_vidx"}, {29'd0, vidx_v[d]}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_v[d]}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_v[d]}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass_v[d]}, 32'd0);
        chk({tag, "_err"},  {28'd0, err_v[d]}, 32'd0);
    endtask

    // Expects start to be high so the coming rising edge accepts the run.
    // Model: vector k occupies cycles [k*h, (k+1)*h) after acceptance and its
    // sample lands on edge (k+1)*h; the result appears right after edge 8h.
    task automatic run_body(input int d, input int h, input logic [7:0] mask,
                            input bit drop_start, input bit pulse_during);
        int exp_e;
        int total;
        mask_v[d] = mask;
        total     = $countones(mask);
        @(posedge clk);
        for (int t = 0; t < 8 * h; t++) begin
            @(negedge clk);
            if (t == 0 && drop_start) start_v[d] = 1'b0;
            if (pulse_during) start_v[d] = (t < 8 * h - 2) ? 1'($urandom % 2) : 1'b0;
            exp_e = 0;
            for (int k = 0; k < 8; k++)
                if ((k + 1) * h <= t && mask[k]) exp_e++;
            chk("run_vidx", {29'd0, vidx_v[d]}, t / h);
            chk("run_abc",  {29'd0, a_v[d], b_v[d], c_v[d]}, t / h);
            chk("run_busy", {31'd0, busy_v[d]}, 32'd1);
            chk("run_done", {31'd0, done_v[d]}, 32'd0);
            chk("run_pass", {31'd0, pass_v[d]}, 32'd0);
            chk("run_err",  {28'd0, err_v[d]}, exp_e);
        end
        @(negedge clk);
        chk("end_done", {31'd0, done_v[d]}, 32'd1);
        chk("end_busy", {31'd0, busy_v[d]}, 32'd0);
        chk("end_err",  {28'd0, err_v[d]}, total);
        chk("end_pass", {31'd0, pass_v[d]}, (total == 0) ? 32'd1 : 32'd0);
        chk("end_vidx", {29'd0, vidx_v[d]}, 32'd0);
        chk("end_abc",  {29'd0, a_v[d], b_v[d], c_v[d]}, 32'd0);
        @(negedge clk);
        chk("post_done", {31'd0, done_v[d]}, 32'd0);
        chk("post_busy", {31'd0, busy_v[d]}, 32'd0);
        chk("post_err",  {28'd0, err_v[d]}, total);
        chk("post_pass", {31'd0, pass_v[d]}, (total == 0) ? 32'd1 : 32'd0);
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        mask_v  = '0;

        // Reset with random start and y activity.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_v = 2'($urandom);
            mask_v  = {8'($urandom), 8'($urandom)};
            #1;
            chk_idle_zero(0, "rst0");
            chk_idle_zero(1, "rst1");
        end
        @(negedge clk);
        start_v = '0;
        mask_v  = '0;
        rst_n   = 1'b1;
        gap(2);
        chk_idle_zero(0, "idle0");

        // H=2 clean run from a single-cycle start pulse.
        start_v[0] = 1'b1;
        run_body(0, 2, 8'h00, 1'b1, 1'b0);

        // y stuck at 0, stuck at 1, inverted.
        gap(1);
        start_v[0] = 1'b1;
        run_body(0, 2, 8'hFE, 1'b1, 1'b0);
        gap(2);
        start_v[0] = 1'b1;
        run_body(0, 2, 8'h01, 1'b1, 1'b0);
        gap(1);
        start_v[0] = 1'b1;
        run_body(0, 2, 8'hFF, 1'b1, 1'b0);

        // H=1 with start held: faulty run, then back-to-back clean run that
        // must clear err_count at acceptance.
        gap(1);
        start_v[1] = 1'b1;
        run_body(1, 1, 8'($urandom) | 8'h10, 1'b0, 1'b0);
        run_body(1, 1, 8'h00, 1'b1, 1'b0);

        // start pulses during a run are ignored.
        gap(2);
        start_v[1] = 1'b1;
        run_body(1, 1, 8'h00, 1'b0, 1'b1);
        gap(2);

        // Randomized runs on either instance.
        for (int i = 0; i < 8; i++) begin
            int d;
            d = int'($urandom % 2);
            gap(int'($urandom_range(1, 3)));
            start_v[d] = 1'b1;
            run_body(d, (d == 0) ? 2 : 1, 8'($urandom), 1'b1, 1'b0);
        end

        // Asynchronous reset in the middle of vector 4.
        gap(1);
        mask_v[0]  = 8'h00;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        gap(8);
        chk("mid_vidx", {29'd0, vidx_v[0]}, 32'd4);
        chk("mid_busy", {31'd0, busy_v[0]}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_zero(0, "arst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("arst_done", {31'd0, done_v[0]}, 32'd0);
            chk("arst_busy", {31'd0, busy_v[0]}, 32'd0);
        end
        start_v[0] = 1'b1;
        run_body(0, 2, 8'h00, 1'b1, 1'b0);

        gap(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/or3_vector_sequencer.md
Name: or3_vector_sequencer

Overview:
Upstream stimulus stage and downstream checker for the 3-input OR gate-level cell. On a start request it drives all 8 input combinations onto a, b and c in ascending order, with a as the MSB. It holds each combination for a programmable number of cycles and samples the cell output y at the end of each hold. It compares y against the expected a|b|c, counts mismatches, and reports done and pass. This turns the OR cell into a self-checking clocked block for board-level and regression use.

Parameters:
HOLD_CYCLES, 2, number of clock cycles each vector is held on a/b/c before y is sampled (legal range 1..15)

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  run request; sampled on a rising edge, accepted only in IDLE
y  input  1  output of the OR cell under test
a  output  1  OR cell input A (MSB of vector index)
b  output  1  OR cell input B
c  output  1  OR cell input C (LSB of vector index)
vec_idx  output  3  index of the vector currently driven; equals {a,b,c} while busy
busy  output  1  high from start acceptance until the final sample
done  output  1  one-cycle pulse when a run completes
pass  output  1  registered with done: 1 when err_count==0; held until the next start is accepted
err_count  output  4  number of mismatching samples in the current or last run (0..8)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a=b=c=0; vec_idx=0; hold counter=0; busy=0; done=0; pass=0; err_count=0. A reset mid-run aborts the run immediately; no partial result is reported.
- States: IDLE, DRIVE, DONE. All outputs are registered.
- IDLE: start=1 at an edge triggers:
  - go to DRIVE; vec_idx=0; {a,b,c}=000; hold counter=0
  - busy=1; err_count=0; pass=0
  - start=0 leaves all outputs unchanged.
- DRIVE: the hold counter increments each edge. On the edge where counter==HOLD_CYCLES-1:
  - sample y and compare with (a|b|c); on mismatch, err_count+=1 (max 8, no wrap possible)
  - if vec_idx<7: vec_idx+=1, {a,b,c}=new vec_idx, counter=0
  - if vec_idx==7: go to DONE; busy=0; done=1; pass=(final err_count==0, including this sample); {a,b,c}=000; vec_idx=0
- DONE: lasts exactly one cycle. done=1 during it. Next edge goes to IDLE with done=0. pass and err_count are held.
- Timing: if start is accepted at edge E0, vector k is visible for the cycles between edges E0+k*H and E0+(k+1)*H (H=HOLD_CYCLES). y for vector k is sampled at edge E0+(k+1)*H. done is high for the cycle after edge E0+8H. Total run length is 8H cycles.
- start is ignored in DRIVE and DONE; a level-held start retriggers only once back in IDLE, i.e. one idle cycle minimum between runs.
- y is treated as combinational from a/b/c; the H-cycle hold provides settle margin. No X handling: X on y counts as a mismatch in simulation.

Test Plan:
1. Assert rst_n=0 with random start/y -> a=b=c=0, vec_idx=0, busy=0, done=0, pass=0, err_count=0.
2. H=2, y=a|b|c, 1-cycle start pulse -> {a,b,c} steps 000..111, each 2 cycles; busy 16 cycles; done 1-cycle pulse right after; err_count=0, pass=1.
3. y tied 0, H=2 -> err_count=7, pass=0; y tied 1 -> err_count=1, pass=0; y=~(a|b|c) -> err_count=8, pass=0.
4. H=1, correct y, start held high continuously -> run of 8 cycles, done, one IDLE cycle, second run starts with err_count cleared to 0 at acceptance; start pulses during busy are ignored.
5. Correct y, rst_n pulsed low while vec_idx=4 -> all outputs 0 immediately (asynchronous), no done pulse; after release the block stays in IDLE until the next start, then completes a clean run with pass=1.
